ex_mem_latch: RTL and testbench
===============================

Name: ex_mem_latch

Overview:
- EX/MEM pipeline register of the 5-stage MIPS datapath. Consumes the ID/EX register outputs after the ALU and feeds the MEM stage.
- Owns the data-memory request handshake. It drives dmemREN/dmemWEN from the latched instruction, holds them until dhit, and captures load data.
- Reports mem_busy to the hazard unit so upstream stages stall while a request is outstanding.

Parameters:
- WORD_W, 32, data/address width.
- REG_W, 5, register select width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- ihit  in  1  instruction fetch hit; the pipeline may advance.
- flush  in  1  squash the incoming instruction (branch/jump taken).
- dREN_in  in  1  load from EX.
- dWEN_in  in  1  store from EX.
- regWrite_in  in  1  writeback enable.
- MemtoReg_in  in  1  writeback source select.
- wsel_in  in  REG_W  destination register.
- aluResult_in  in  WORD_W  ALU output / memory address.
- storeData_in  in  WORD_W  rdat2 forwarded from EX.
- pcp4_in  in  WORD_W  PC+4 (for JAL writeback).
- HALT_in  in  1  halt marker.
- dhit  in  1  data memory completed the current request.
- dmemload  in  WORD_W  load data, valid when dhit.
- dmemREN  out  1  data read request.
- dmemWEN  out  1  data write request.
- dmemaddr  out  WORD_W  request address.
- dmemstore  out  WORD_W  store data.
- regWrite_out  out  1  latched writeback enable.
- MemtoReg_out  out  1  latched source select.
- wsel_out  out  REG_W  latched destination register.
- aluResult_out  out  WORD_W  latched ALU result.
- dload_out  out  WORD_W  captured load data.
- pcp4_out  out  WORD_W  latched PC+4.
- HALT_out  out  1  sticky halt.
- mem_busy  out  1  request outstanding; stall upstream.

Behaviour:
- Reset (RST=1, asynchronous): all outputs and stored fields are 0, state is IDLE. Reset mid-request drops the request immediately, with no wait for dhit.
- FSM states:
  - IDLE: no memory op latched.
  - REQ: request outstanding.
  - DONE: request served; waiting to advance.
- Advance condition: adv = ihit & ~mem_busy & ~HALT_out.
- On adv, every _in field is loaded into the register.
  - If flush=1 on the adv edge, load a bubble instead: all control bits 0 (dREN, dWEN, regWrite, HALT) and data fields 0.
  - Next state after a load: REQ if the loaded dREN|dWEN is 1, else IDLE.
- No adv: all fields hold. flush without adv has no effect.
- mem_busy = (state==REQ), combinational from state. It is high the same cycle the request is asserted.
- dmemREN = stored dREN & (state==REQ); dmemWEN = stored dWEN & (state==REQ).
- dmemaddr = aluResult_out; dmemstore = stored store data. Both are stable through the whole REQ.
- REQ with dhit=1:
  - Capture dload_out <= dmemload, for loads only. Stores leave dload_out unchanged.
  - Go to DONE. The request deasserts the next cycle and is never reissued for the same instruction.
- REQ with dhit=0: stay in REQ; address, data and enables are held.
- DONE with adv: load the next instruction per the rules above. DONE with no adv: hold.
- A single instruction is one REQ of one or more cycles, followed by DONE. Back-to-back memory ops get distinct REQ phases.
- dREN_in and dWEN_in both 1 is illegal. The block must not crash: it asserts both enables and relies on memory arbitration.
- HALT:
  - When a bubble-free instruction with HALT_in=1 is loaded, HALT_out becomes 1 and stays sticky until reset.
  - adv is then blocked and the register freezes.
- dhit outside REQ is ignored.
- Latency: EX to MEM outputs is 1 cycle. Load data is valid in dload_out the cycle after dhit.

Test Plan:
- Reset during REQ (addr 0x100, dREN latched) -> same-cycle dmemREN=0, mem_busy=0, all outputs 0.
- ALU op: aluResult_in=0x1234, regWrite=1, wsel=5, ihit=1 -> next cycle aluResult_out=0x1234, wsel_out=5, dmemREN=dmemWEN=0, mem_busy=0.
- Load at 0x80, dhit after 3 cycles with dmemload=0xDEADBEEF:
  - dmemREN=1 and mem_busy=1 for exactly 3 cycles, dmemaddr=0x80 throughout.
  - Then dload_out=0xDEADBEEF and dmemREN=0; ihit held high does not advance until DONE.
- Store at 0x40, data 0xCAFE, dhit in cycle 1 -> dmemWEN=1 for one cycle, dmemstore=0xCAFE, dload_out unchanged.
- flush=1 with ihit=1 on a load/regWrite instruction -> bubble latched: no request, regWrite_out=0. flush with ihit=0 -> state unchanged.
- HALT_in=1 loaded -> HALT_out=1. Subsequent ihit pulses with new inputs leave all outputs frozen until RST.

Source files
------------

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register for the 5-stage MIPS datapath.
// Latches the EX results and runs the data-memory request handshake (IDLE -> REQ -> DONE).
module ex_mem_latch #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic              flush,
    input  logic              dREN_in,
    input  logic              dWEN_in,
    input  logic              regWrite_in,
    input  logic              MemtoReg_in,
    input  logic [REG_W-1:0]  wsel_in,
    input  logic [WORD_W-1:0] aluResult_in,
    input  logic [WORD_W-1:0] storeData_in,
    input  logic [WORD_W-1:0] pcp4_in,
    input  logic              HALT_in,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              regWrite_out,
    output logic              MemtoReg_out,
    output logic [REG_W-1:0]  wsel_out,
    output logic [WORD_W-1:0] aluResult_out,
    output logic [WORD_W-1:0] dload_out,
    output logic [WORD_W-1:0] pcp4_out,
    output logic              HALT_out,
    output logic              mem_busy
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t            r_state;
    logic              r_dren;
    logic              r_dwen;
    logic              r_regwrite;
    logic              r_memtoreg;
    logic              r_halt;
    logic [REG_W-1:0]  r_wsel;
    logic [WORD_W-1:0] r_alu;
    logic [WORD_W-1:0] r_store;
    logic [WORD_W-1:0] r_pcp4;
    logic [WORD_W-1:0] r_dload;

    logic w_busy;
    logic w_adv;
    logic w_load_mem;

    assign w_busy     = (r_state == REQ);
    assign w_adv      = ihit & ~w_busy & ~r_halt;
    assign w_load_mem = ~flush & (dREN_in | dWEN_in);

    // NOTE: state registers use non-blocking assignments so every field samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= IDLE;
            r_dren     <= 1'b0;
            r_dwen     <= 1'b0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_halt     <= 1'b0;
            r_wsel     <= '0;
            r_alu      <= '0;
            r_store    <= '0;
            r_pcp4     <= '0;
            r_dload    <= '0;
        end else if (w_adv) begin
            if (flush) begin
                r_dren     <= 1'b0;
                r_dwen     <= 1'b0;
                r_regwrite <= 1'b0;
                r_memtoreg <= 1'b0;
                r_halt     <= 1'b0;
                r_wsel     <= '0;
                r_alu      <= '0;
                r_store    <= '0;
                r_pcp4     <= '0;
            end else begin
                r_dren     <= dREN_in;
                r_dwen     <= dWEN_in;
                r_regwrite <= regWrite_in;
                r_memtoreg <= MemtoReg_in;
                r_halt     <= HALT_in;
                r_wsel     <= wsel_in;
                r_alu      <= aluResult_in;
                r_store    <= storeData_in;
                r_pcp4     <= pcp4_in;
            end
            r_state <= w_load_mem ? REQ : IDLE;
        end else if (w_busy && dhit) begin
            // Loads capture data; stores leave the previous load value intact.
            if (r_dren) begin
                r_dload <= dmemload;
            end
            r_state <= DONE;
        end
    end

    assign mem_busy      = w_busy;
    assign dmemREN       = r_dren & w_busy;
    assign dmemWEN       = r_dwen & w_busy;
    assign dmemaddr      = r_alu;
    assign dmemstore     = r_store;
    assign regWrite_out  = r_regwrite;
    assign MemtoReg_out  = r_memtoreg;
    assign wsel_out      = r_wsel;
    assign aluResult_out = r_alu;
    assign dload_out     = r_dload;
    assign pcp4_out      = r_pcp4;
    assign HALT_out      = r_halt;

endmodule

// File: tb/tb_ex_mem_latch.sv
// Self-checking bench for ex_mem_latch: per-cycle model comparison plus directed literal checks.
module tb_ex_mem_latch;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ihit, flush, dREN_in, dWEN_in, regWrite_in, MemtoReg_in, HALT_in, dhit;
    logic [4:0]  wsel_in;
    logic [31:0] aluResult_in, storeData_in, pcp4_in, dmemload;
    logic        dmemREN, dmemWEN, regWrite_out, MemtoReg_out, HALT_out, mem_busy;
    logic [4:0]  wsel_out;
    logic [31:0] dmemaddr, dmemstore, aluResult_out, dload_out, pcp4_out;

    int n_checks = 0;
    int n_errors = 0;

    ex_mem_latch #(.WORD_W(32), .REG_W(5)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .flush(flush),
        .dREN_in(dREN_in), .dWEN_in(dWEN_in), .regWrite_in(regWrite_in),
        .MemtoReg_in(MemtoReg_in), .wsel_in(wsel_in), .aluResult_in(aluResult_in),
        .storeData_in(storeData_in), .pcp4_in(pcp4_in), .HALT_in(HALT_in),
        .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .regWrite_out(regWrite_out), .MemtoReg_out(MemtoReg_out), .wsel_out(wsel_out),
        .aluResult_out(aluResult_out), .dload_out(dload_out), .pcp4_out(pcp4_out),
        .HALT_out(HALT_out), .mem_busy(mem_busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an instruction slot plus a "request pending" flag; pending blocks loading.
    logic        m_pending, m_dren, m_dwen, m_rw, m_m2r, m_halt;
    logic [4:0]  m_wsel;
    logic [31:0] m_alu, m_store, m_pcp4, m_dload;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_pending <= 0; m_dren <= 0; m_dwen <= 0; m_rw <= 0; m_m2r <= 0; m_halt <= 0;
            m_wsel <= 0; m_alu <= 0; m_store <= 0; m_pcp4 <= 0; m_dload <= 0;
        end else if (m_pending) begin
            if (dhit) begin
                m_pending <= 0;
                if (m_dren) m_dload <= dmemload;
            end
        end else if (ihit && !m_halt) begin
            m_pending <= !flush && (dREN_in || dWEN_in);
            m_dren  <= flush ? 1'b0 : dREN_in;
            m_dwen  <= flush ? 1'b0 : dWEN_in;
            m_rw    <= flush ? 1'b0 : regWrite_in;
            m_m2r   <= flush ? 1'b0 : MemtoReg_in;
            m_halt  <= flush ? 1'b0 : HALT_in;
            m_wsel  <= flush ? 5'd0 : wsel_in;
            m_alu   <= flush ? 32'd0 : aluResult_in;
            m_store <= flush ? 32'd0 : storeData_in;
            m_pcp4  <= flush ? 32'd0 : pcp4_in;
        end
    end

    always @(negedge CLK) begin
        check("cmp_dmemREN",   {31'd0, dmemREN},      {31'd0, m_dren && m_pending});
        check("cmp_dmemWEN",   {31'd0, dmemWEN},      {31'd0, m_dwen && m_pending});
        check("cmp_mem_busy",  {31'd0, mem_busy},     {31'd0, m_pending});
        check("cmp_dmemaddr",  dmemaddr,              m_alu);
        check("cmp_dmemstore", dmemstore,             m_store);
        check("cmp_regWrite",  {31'd0, regWrite_out}, {31'd0, m_rw});
        check("cmp_MemtoReg",  {31'd0, MemtoReg_out}, {31'd0, m_m2r});
        check("cmp_wsel",      {27'd0, wsel_out},     {27'd0, m_wsel});
        check("cmp_aluResult", aluResult_out,         m_alu);
        check("cmp_dload",     dload_out,             m_dload);
        check("cmp_pcp4",      pcp4_out,              m_pcp4);
        check("cmp_HALT",      {31'd0, HALT_out},     {31'd0, m_halt});
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_in(input logic dren, input logic dwen, input logic rw, input logic m2r,
                          input logic [4:0] ws, input logic [31:0] alu, input logic [31:0] st,
                          input logic [31:0] pc, input logic halt, input logic ih, input logic fl);
        dREN_in = dren; dWEN_in = dwen; regWrite_in = rw; MemtoReg_in = m2r;
        wsel_in = ws; aluResult_in = alu; storeData_in = st; pcp4_in = pc;
        HALT_in = halt; ihit = ih; flush = fl;
    endtask

    initial begin
        set_in(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 0, 0);
        dhit = 0; dmemload = 32'd0;
        tick(); tick();
        check("reset_alu",  aluResult_out, 32'd0);
        check("reset_busy", {31'd0, mem_busy}, 32'd0);
        check("reset_halt", {31'd0, HALT_out}, 32'd0);
        RST = 0;

        // Plain ALU op
        set_in(0, 0, 1, 0, 5'd5, 32'h1234, 32'd0, 32'h10, 0, 1, 0);
        tick();
        check("alu_result",  aluResult_out, 32'h1234);
        check("alu_wsel",    {27'd0, wsel_out}, 32'd5);
        check("alu_regw",    {31'd0, regWrite_out}, 32'd1);
        check("alu_ren",     {31'd0, dmemREN}, 32'd0);
        check("alu_busy",    {31'd0, mem_busy}, 32'd0);

        // Load at 0x80, dhit on the third request cycle; ihit stays high meanwhile
        set_in(1, 0, 1, 1, 5'd7, 32'h80, 32'd0, 32'h14, 0, 1, 0);
        tick();
        set_in(0, 0, 1, 0, 5'd2, 32'h999, 32'd0, 32'h18, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            check("ld_ren",  {31'd0, dmemREN}, 32'd1);
            check("ld_busy", {31'd0, mem_busy}, 32'd1);
            check("ld_addr", dmemaddr, 32'h80);
            if (i == 2) begin
                dhit = 1; dmemload = 32'hDEADBEEF;
            end
            tick();
        end
        dhit = 0;
        check("ld_done_data", dload_out, 32'hDEADBEEF);
        check("ld_done_ren",  {31'd0, dmemREN}, 32'd0);
        check("ld_done_busy", {31'd0, mem_busy}, 32'd0);
        check("ld_done_addr", aluResult_out, 32'h80);

        // Store at 0x40, served in its first request cycle
        set_in(0, 1, 0, 0, 5'd0, 32'h40, 32'hCAFE, 32'h1C, 0, 1, 0);
        tick();
        check("st_wen",   {31'd0, dmemWEN}, 32'd1);
        check("st_addr",  dmemaddr, 32'h40);
        check("st_data",  dmemstore, 32'hCAFE);
        dhit = 1; dmemload = 32'h55555555;
        ihit = 0;
        tick();
        dhit = 0;
        check("st_wen_off", {31'd0, dmemWEN}, 32'd0);
        check("st_dload",   dload_out, 32'hDEADBEEF);
        tick();
        check("st_no_reissue", {31'd0, dmemWEN}, 32'd0);

        // Flush with advance latches a bubble
        set_in(1, 0, 1, 1, 5'd8, 32'h200, 32'd0, 32'h20, 0, 1, 1);
        tick();
        check("fl_busy", {31'd0, mem_busy}, 32'd0);
        check("fl_regw", {31'd0, regWrite_out}, 32'd0);
        check("fl_alu",  aluResult_out, 32'd0);
        // Flush without advance, plus a stray dhit outside REQ
        set_in(0, 0, 1, 0, 5'd4, 32'h77, 32'd0, 32'h24, 0, 0, 1);
        dhit = 1; dmemload = 32'h1111;
        tick();
        dhit = 0;
        check("fl_hold_alu", aluResult_out, 32'd0);
        check("stray_dhit",  dload_out, 32'hDEADBEEF);

        // Back-to-back loads get separate request phases
        set_in(1, 0, 1, 1, 5'd9, 32'h300, 32'd0, 32'h28, 0, 1, 0);
        tick();
        check("b2b_a_addr", dmemaddr, 32'h300);
        dhit = 1; dmemload = 32'hA;
        set_in(1, 0, 1, 1, 5'd10, 32'h304, 32'd0, 32'h2C, 0, 1, 0);
        tick();
        dhit = 0;
        check("b2b_gap_ren", {31'd0, dmemREN}, 32'd0);
        check("b2b_a_data",  dload_out, 32'hA);
        tick();
        check("b2b_b_ren",  {31'd0, dmemREN}, 32'd1);
        check("b2b_b_addr", dmemaddr, 32'h304);
        dhit = 1; dmemload = 32'hB;
        set_in(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 0, 0);
        tick();
        dhit = 0;
        check("b2b_b_data", dload_out, 32'hB);

        // Illegal load+store: both enables asserted
        set_in(1, 1, 0, 0, 5'd0, 32'h400, 32'h9, 32'h30, 0, 1, 0);
        tick();
        check("both_ren", {31'd0, dmemREN}, 32'd1);
        check("both_wen", {31'd0, dmemWEN}, 32'd1);
        dhit = 1; dmemload = 32'hC;
        ihit = 0;
        tick();
        dhit = 0;
        check("both_done", {30'd0, dmemREN, dmemWEN}, 32'd0);

        // Asynchronous reset in the middle of a request
        set_in(1, 0, 1, 1, 5'd3, 32'h100, 32'd0, 32'h34, 0, 1, 0);
        tick();
        check("rst_pre_ren", {31'd0, dmemREN}, 32'd1);
        ihit = 0;
        #2 RST = 1;
        #1;
        check("rst_ren",   {31'd0, dmemREN}, 32'd0);
        check("rst_busy",  {31'd0, mem_busy}, 32'd0);
        check("rst_addr",  dmemaddr, 32'd0);
        check("rst_dload", dload_out, 32'd0);
        tick();
        RST = 0;

        // HALT is sticky and freezes the register
        set_in(0, 0, 1, 0, 5'd3, 32'h5000, 32'd0, 32'h44, 1, 1, 0);
        tick();
        check("halt_set", {31'd0, HALT_out}, 32'd1);
        set_in(1, 0, 1, 1, 5'd9, 32'h6000, 32'd1, 32'h48, 0, 1, 0);
        repeat (3) tick();
        check("halt_alu",  aluResult_out, 32'h5000);
        check("halt_wsel", {27'd0, wsel_out}, 32'd3);
        check("halt_ren",  {31'd0, dmemREN}, 32'd0);
        check("halt_keep", {31'd0, HALT_out}, 32'd1);
        RST = 1;
        tick();
        check("halt_clr", {31'd0, HALT_out}, 32'd0);
        RST = 0;
        ihit = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
